ysyx_24100006_memu: RTL and testbench

Memory-access stage of the 5-stage NPC pipeline, sitting between the EXE_MEM register and the MEM_WB boundary. It consumes the EXEU's address, access type, mask and write-back payload, runs one load or store at a time on a simple request/response data bus, replaces `wdata_gpr` with extended load data, and holds the result in a one-entry output register toward WBU. Non-memory instructions pass through the same output register with 1-cycle latency at full throughput.

---
 rtl/ysyx_24100006_pkg.sv | 33 +++
 rtl/ysyx_24100006_memu_if.sv | 28 ++
 rtl/ysyx_24100006_lsu_align.sv | 83 ++++++++
 rtl/ysyx_24100006_memu.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_24100006_memu.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24100006_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_pkg
// Shared encodings for the memory-access stage:
//   - Mem_Mask load encodings (size in [1:0], unsigned flag in [2])
//   - store size encodings (Mem_Mask[1:0] only)
//   - sram_read_write bit positions
//   - MEMU FSM state enum
// ---------------------------------------------------------------------------
package ysyx_24100006_pkg;

  // Load mask encodings: bits[1:0] give the size, bit[2] selects zero-extension.
  localparam logic [2:0] MASK_LB  = 3'b000;
  localparam logic [2:0] MASK_LH  = 3'b001;
  localparam logic [2:0] MASK_LW  = 3'b010;
  localparam logic [2:0] MASK_LBU = 3'b100;
  localparam logic [2:0] MASK_LHU = 3'b101;

  // Store sizes, taken from Mem_Mask[1:0].
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // sram_read_write bit positions.
  localparam int SRW_LOAD_BIT  = 0;
  localparam int SRW_STORE_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } memu_state_e;

endpackage

// File: rtl/ysyx_24100006_memu_if.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_memu_if
// Simple request/response data bus between MEMU (master) and memory (slave).
//   dreq_valid/dreq_ready : request handshake
//   dreq_write, dreq_addr, dreq_wdata, dreq_wstrb : request fields
//   drsp_valid, drsp_rdata, drsp_err : response (no ready, master always takes it)
// ---------------------------------------------------------------------------
interface ysyx_24100006_memu_if;
  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;
  logic        drsp_err;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_wstrb,
    input  dreq_ready, drsp_valid, drsp_rdata, drsp_err
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_wstrb,
    output dreq_ready, drsp_valid, drsp_rdata, drsp_err
  );
endinterface

// File: rtl/ysyx_24100006_lsu_align.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_lsu_align
// Purely combinational lane steering for loads and stores.
//   addr_lo    in  2 : low address bits selecting the byte/half lane
//   mask       in  3 : Mem_Mask (size + unsigned flag)
//   store_data in 32 : rs2 value
//   rdata      in 32 : raw word returned by the bus
//   wstrb      out 4 : byte strobes for a store
//   wdata      out 32: store data replicated onto every lane
//   load_data  out 32: extracted and extended load value
// Misaligned offsets are not trapped; the excess low bits are simply ignored.
// ---------------------------------------------------------------------------
module ysyx_24100006_lsu_align
  import ysyx_24100006_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mask,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: replicate the datum so the selected strobes pick the right lane.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0000_0000;
    case (mask[1:0])
      SIZE_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SIZE_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_W: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: begin
        // Undefined size: issue no byte enables so memory is left untouched.
        wdata = store_data;
        wstrb = 4'b0000;
      end
    endcase
  end

  // Lane selection for byte and halfword loads.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Load side: sign- or zero-extend the selected lane.
  always_comb begin
    load_data = 32'h0000_0000;
    case (mask)
      MASK_LB:  load_data = {{24{byte_s[7]}}, byte_s};
      MASK_LBU: load_data = {24'h00_0000, byte_s};
      MASK_LH:  load_data = {{16{half_s[15]}}, half_s};
      MASK_LHU: load_data = {16'h0000, half_s};
      MASK_LW:  load_data = rdata;
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_memu.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_memu
// Memory-access stage between EXE_MEM and MEM_WB. Runs one load/store at a
// time on the data bus and holds results in a one-entry output register.
//   clk, reset (async, active-low)
//   mem_out_valid / mem_out_ready : upstream handshake
//   alu_result, sram_read_write, Mem_Mask, store_data : access description
//   *_i / *_o : write-back payload in / registered payload toward WBU
//   wb_valid / wb_ready : downstream handshake
//   dbus : data bus master (request/response)
//   mem_err : one-cycle pulse with wb_valid for an erroring access
//   mem_is_load, mem_fw_data : forwarding hints
// ---------------------------------------------------------------------------
module ysyx_24100006_memu
  import ysyx_24100006_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_out_valid,
  output logic        mem_out_ready,
  input  logic [31:0] alu_result,
  input  logic [1:0]  sram_read_write,
  input  logic [2:0]  Mem_Mask,
  input  logic [31:0] store_data,
  input  logic [31:0] wdata_gpr_i,
  input  logic [31:0] wdata_csr_i,
  input  logic        Gpr_Write_i,
  input  logic        Csr_Write_i,
  input  logic        irq_i,
  input  logic        is_break_i,
  input  logic [3:0]  Gpr_Write_Addr_i,
  input  logic [11:0] Csr_Write_Addr_i,
  input  logic [1:0]  Gpr_Write_RD_i,
  output logic [31:0] wdata_gpr_o,
  output logic [31:0] wdata_csr_o,
  output logic        Gpr_Write_o,
  output logic        Csr_Write_o,
  output logic        irq_o,
  output logic        is_break_o,
  output logic [3:0]  Gpr_Write_Addr_o,
  output logic [11:0] Csr_Write_Addr_o,
  output logic [1:0]  Gpr_Write_RD_o,
  output logic        wb_valid,
  input  logic        wb_ready,
  ysyx_24100006_memu_if.master dbus,
  output logic        mem_err,
  output logic        mem_is_load,
  output logic [31:0] mem_fw_data
);

  memu_state_e state_r;
  logic [1:0]  addr_lo_r;
  logic [2:0]  mask_r;
  logic        dreq_valid_r;
  logic        dreq_write_r;
  logic [31:0] dreq_addr_r;
  logic [31:0] dreq_wdata_r;
  logic [3:0]  dreq_wstrb_r;

  logic        accept_s;
  logic        is_mem_s;
  logic        idle_s;
  logic [1:0]  addr_lo_sel_s;
  logic [2:0]  mask_sel_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s;
  logic [31:0] load_data_s;

  assign idle_s        = (state_r == ST_IDLE);
  assign mem_out_ready = idle_s && (!wb_valid || wb_ready);
  assign accept_s      = mem_out_valid && mem_out_ready;
  assign is_mem_s      = sram_read_write[SRW_LOAD_BIT] || sram_read_write[SRW_STORE_BIT];

  // In IDLE the aligner builds the request from live inputs; afterwards it
  // extracts the load value using the latched offset and mask.
  assign addr_lo_sel_s = idle_s ? alu_result[1:0] : addr_lo_r;
  assign mask_sel_s    = idle_s ? Mem_Mask : mask_r;

  ysyx_24100006_lsu_align u_align (
    .addr_lo    (addr_lo_sel_s),
    .mask       (mask_sel_s),
    .store_data (store_data),
    .rdata      (dbus.drsp_rdata),
    .wstrb      (wstrb_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  assign dbus.dreq_valid = dreq_valid_r;
  assign dbus.dreq_write = dreq_write_r;
  assign dbus.dreq_addr  = dreq_addr_r;
  assign dbus.dreq_wdata = dreq_wdata_r;
  assign dbus.dreq_wstrb = dreq_wstrb_r;
  assign mem_fw_data     = wdata_gpr_o;

  // Access FSM together with the output register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_IDLE;
      addr_lo_r        <= 2'b00;
      mask_r           <= 3'b000;
      dreq_valid_r     <= 1'b0;
      dreq_write_r     <= 1'b0;
      dreq_addr_r      <= 32'h0000_0000;
      dreq_wdata_r     <= 32'h0000_0000;
      dreq_wstrb_r     <= 4'b0000;
      wb_valid         <= 1'b0;
      mem_err          <= 1'b0;
      mem_is_load      <= 1'b0;
      wdata_gpr_o      <= 32'h0000_0000;
      wdata_csr_o      <= 32'h0000_0000;
      Gpr_Write_o      <= 1'b0;
      Csr_Write_o      <= 1'b0;
      irq_o            <= 1'b0;
      is_break_o       <= 1'b0;
      Gpr_Write_Addr_o <= 4'h0;
      Csr_Write_Addr_o <= 12'h000;
      Gpr_Write_RD_o   <= 2'b00;
    end else begin
      mem_err <= 1'b0;
      // Drain by default; a refill below in the same cycle takes priority.
      if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            // The slot is free or draining this cycle, so the payload can be
            // parked in the output register right away; loads overwrite
            // wdata_gpr_o when the response returns.
            wdata_gpr_o      <= wdata_gpr_i;
            wdata_csr_o      <= wdata_csr_i;
            Gpr_Write_o      <= Gpr_Write_i;
            Csr_Write_o      <= Csr_Write_i;
            irq_o            <= irq_i;
            is_break_o       <= is_break_i;
            Gpr_Write_Addr_o <= Gpr_Write_Addr_i;
            Csr_Write_Addr_o <= Csr_Write_Addr_i;
            Gpr_Write_RD_o   <= Gpr_Write_RD_i;
            if (is_mem_s) begin
              // Encoding 11 has the store bit set and is handled as a store.
              addr_lo_r    <= alu_result[1:0];
              mask_r       <= Mem_Mask;
              dreq_valid_r <= 1'b1;
              dreq_write_r <= sram_read_write[SRW_STORE_BIT];
              dreq_addr_r  <= {alu_result[31:2], 2'b00};
              dreq_wdata_r <= wdata_s;
              dreq_wstrb_r <= sram_read_write[SRW_STORE_BIT] ? wstrb_s : 4'b0000;
              mem_is_load  <= !sram_read_write[SRW_STORE_BIT];
              state_r      <= ST_REQ;
            end else begin
              wb_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (dbus.dreq_ready) begin
            dreq_valid_r <= 1'b0;
            state_r      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dbus.drsp_valid) begin
            if (!dreq_write_r) begin
              wdata_gpr_o <= dbus.drsp_err ? 32'h0000_0000 : load_data_s;
            end
            mem_err     <= dbus.drsp_err;
            wb_valid    <= 1'b1;
            mem_is_load <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          dreq_valid_r <= 1'b0;
          mem_is_load  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_memu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24100006_memu
// Directed bench for the MEMU stage: a table of single load/store accesses at
// minimum latency, plus sequences for pass-through throughput, bus and
// write-back backpressure, and reset during an outstanding access.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24100006_memu;

  logic        clk;
  logic        reset;
  logic        mem_out_valid;
  logic        mem_out_ready;
  logic [31:0] alu_result;
  logic [1:0]  sram_read_write;
  logic [2:0]  Mem_Mask;
  logic [31:0] store_data;
  logic [31:0] wdata_gpr_i;
  logic [31:0] wdata_csr_i;
  logic        Gpr_Write_i;
  logic        Csr_Write_i;
  logic        irq_i;
  logic        is_break_i;
  logic [3:0]  Gpr_Write_Addr_i;
  logic [11:0] Csr_Write_Addr_i;
  logic [1:0]  Gpr_Write_RD_i;
  logic [31:0] wdata_gpr_o;
  logic [31:0] wdata_csr_o;
  logic        Gpr_Write_o;
  logic        Csr_Write_o;
  logic        irq_o;
  logic        is_break_o;
  logic [3:0]  Gpr_Write_Addr_o;
  logic [11:0] Csr_Write_Addr_o;
  logic [1:0]  Gpr_Write_RD_o;
  logic        wb_valid;
  logic        wb_ready;
  logic        mem_err;
  logic        mem_is_load;
  logic [31:0] mem_fw_data;

  ysyx_24100006_memu_if dbus ();

  ysyx_24100006_memu u_dut (
    .clk              (clk),
    .reset            (reset),
    .mem_out_valid    (mem_out_valid),
    .mem_out_ready    (mem_out_ready),
    .alu_result       (alu_result),
    .sram_read_write  (sram_read_write),
    .Mem_Mask         (Mem_Mask),
    .store_data       (store_data),
    .wdata_gpr_i      (wdata_gpr_i),
    .wdata_csr_i      (wdata_csr_i),
    .Gpr_Write_i      (Gpr_Write_i),
    .Csr_Write_i      (Csr_Write_i),
    .irq_i            (irq_i),
    .is_break_i       (is_break_i),
    .Gpr_Write_Addr_i (Gpr_Write_Addr_i),
    .Csr_Write_Addr_i (Csr_Write_Addr_i),
    .Gpr_Write_RD_i   (Gpr_Write_RD_i),
    .wdata_gpr_o      (wdata_gpr_o),
    .wdata_csr_o      (wdata_csr_o),
    .Gpr_Write_o      (Gpr_Write_o),
    .Csr_Write_o      (Csr_Write_o),
    .irq_o            (irq_o),
    .is_break_o       (is_break_o),
    .Gpr_Write_Addr_o (Gpr_Write_Addr_o),
    .Csr_Write_Addr_o (Csr_Write_Addr_o),
    .Gpr_Write_RD_o   (Gpr_Write_RD_o),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .dbus             (dbus),
    .mem_err          (mem_err),
    .mem_is_load      (mem_is_load),
    .mem_fw_data      (mem_fw_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  srw;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] gpr_in;
    logic [31:0] exp_gpr;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwdata;
    logic [3:0]  exp_wstrb;
    logic        exp_write;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int n_tests;
  int n_fail;

  task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", what, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_out_valid    = 1'b0;
    alu_result       = 32'h0;
    sram_read_write  = 2'b00;
    Mem_Mask         = 3'b000;
    store_data       = 32'h0;
    wdata_gpr_i      = 32'h0;
    wdata_csr_i      = 32'h0;
    Gpr_Write_i      = 1'b0;
    Csr_Write_i      = 1'b0;
    irq_i            = 1'b0;
    is_break_i       = 1'b0;
    Gpr_Write_Addr_i = 4'h0;
    Csr_Write_Addr_i = 12'h000;
    Gpr_Write_RD_i   = 2'b00;
    dbus.dreq_ready  = 1'b0;
    dbus.drsp_valid  = 1'b0;
    dbus.drsp_rdata  = 32'h0;
    dbus.drsp_err    = 1'b0;
  endtask

  // One access at minimum latency: accept T, request T+1, response T+2, wb T+3.
  task automatic run_vec(input int i);
    vec_t v;
    logic exp_load;
    v = vecs[i];
    exp_load = (v.srw == 2'b01);
    @(negedge clk);
    chk("accept_ready", i, {31'b0, mem_out_ready}, 32'd1);
    mem_out_valid    = 1'b1;
    sram_read_write  = v.srw;
    Mem_Mask         = v.mask;
    alu_result       = v.addr;
    store_data       = v.sdata;
    wdata_gpr_i      = v.gpr_in;
    Gpr_Write_Addr_i = i[3:0];
    dbus.dreq_ready  = 1'b1;
    @(negedge clk);
    idle_inputs();
    dbus.dreq_ready = 1'b1;
    chk("req_valid", i, {31'b0, dbus.dreq_valid}, 32'd1);
    chk("req_addr", i, dbus.dreq_addr, v.exp_daddr);
    chk("req_write", i, {31'b0, dbus.dreq_write}, {31'b0, v.exp_write});
    chk("req_wstrb", i, {28'b0, dbus.dreq_wstrb}, {28'b0, v.exp_wstrb});
    if (v.exp_write) chk("req_wdata", i, dbus.dreq_wdata, v.exp_dwdata);
    chk("req_busy", i, {31'b0, mem_out_ready}, 32'd0);
    chk("req_is_load", i, {31'b0, mem_is_load}, {31'b0, exp_load});
    @(negedge clk);
    dbus.dreq_ready = 1'b0;
    chk("wait_valid", i, {31'b0, dbus.dreq_valid}, 32'd0);
    chk("wait_is_load", i, {31'b0, mem_is_load}, {31'b0, exp_load});
    dbus.drsp_valid = 1'b1;
    dbus.drsp_rdata = v.rdata;
    dbus.drsp_err   = v.err;
    @(negedge clk);
    dbus.drsp_valid = 1'b0;
    dbus.drsp_err   = 1'b0;
    chk("wb_valid", i, {31'b0, wb_valid}, 32'd1);
    chk("wb_gpr", i, wdata_gpr_o, v.exp_gpr);
    chk("wb_fw", i, mem_fw_data, v.exp_gpr);
    chk("wb_err", i, {31'b0, mem_err}, {31'b0, v.err});
    chk("wb_rd", i, {28'b0, Gpr_Write_Addr_o}, i & 32'hF);
    chk("wb_is_load", i, {31'b0, mem_is_load}, 32'd0);
    @(negedge clk);
    chk("wb_drain", i, {31'b0, wb_valid}, 32'd0);
    chk("err_pulse", i, {31'b0, mem_err}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //          srw    mask    addr           sdata          rdata          err   gpr_in         exp_gpr        exp_daddr      exp_dwdata     wstrb    wr
    vecs[0]  = '{2'b01, 3'b000, 32'h8000_0003, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0000, 32'hFFFF_FF80, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[1]  = '{2'b01, 3'b100, 32'h8000_0003, 32'h0000_0000, 32'h80FF_0000, 1'b0, 32'h0000_0000, 32'h0000_0080, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[2]  = '{2'b10, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 1'b1};
    vecs[3]  = '{2'b10, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0000_0000, 1'b0, 32'h0101_0101, 32'h0101_0101, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 1'b1};
    vecs[4]  = '{2'b10, 3'b010, 32'h8000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h8000_0104, 32'hDEAD_BEEF, 4'b1111, 1'b1};
    vecs[5]  = '{2'b01, 3'b001, 32'h8000_0002, 32'h0000_0000, 32'h8001_7FFF, 1'b0, 32'h0000_0000, 32'hFFFF_8001, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[6]  = '{2'b01, 3'b101, 32'h8000_0000, 32'h0000_0000, 32'h1234_8765, 1'b0, 32'h0000_0000, 32'h0000_8765, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[7]  = '{2'b01, 3'b010, 32'h8000_000C, 32'h0000_0000, 32'hCAFE_BABE, 1'b0, 32'h0000_0000, 32'hCAFE_BABE, 32'h8000_000C, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[8]  = '{2'b01, 3'b010, 32'h8000_0010, 32'h0000_0000, 32'h1111_1111, 1'b1, 32'h0000_0099, 32'h0000_0000, 32'h8000_0010, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[9]  = '{2'b01, 3'b000, 32'h8000_0001, 32'h0000_0000, 32'h0000_7F00, 1'b0, 32'h0000_0000, 32'h0000_007F, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[10] = '{2'b01, 3'b010, 32'h8000_0003, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0000_0000, 32'h0102_0304, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[11] = '{2'b11, 3'b010, 32'h8000_0008, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 32'h0000_0042, 32'h0000_0042, 32'h8000_0008, 32'h0BAD_F00D, 4'b1111, 1'b1};
    vecs[12] = '{2'b01, 3'b001, 32'h8000_0003, 32'h0000_0000, 32'hFF7F_0000, 1'b0, 32'h0000_0000, 32'hFFFF_FF7F, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b0};

    idle_inputs();
    wb_ready = 1'b1;
    reset    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_wb_valid", 0, {31'b0, wb_valid}, 32'd0);
    chk("rst_dreq_valid", 0, {31'b0, dbus.dreq_valid}, 32'd0);
    chk("rst_mem_err", 0, {31'b0, mem_err}, 32'd0);
    chk("rst_is_load", 0, {31'b0, mem_is_load}, 32'd0);
    chk("rst_gpr", 0, wdata_gpr_o, 32'd0);
    chk("rst_fw", 0, mem_fw_data, 32'd0);
    chk("rst_daddr", 0, dbus.dreq_addr, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, {31'b0, mem_out_ready}, 32'd1);

    // Pass-through: four back-to-back ALU results.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        chk("alu_valid", k, {31'b0, wb_valid}, 32'd1);
        chk("alu_gpr", k, wdata_gpr_o, 32'h1000_0000 + k - 1);
      end
      if (k < 4) begin
        chk("alu_ready", k, {31'b0, mem_out_ready}, 32'd1);
        mem_out_valid   = 1'b1;
        sram_read_write = 2'b00;
        wdata_gpr_i     = 32'h1000_0000 + k;
      end else begin
        mem_out_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("alu_drain", 0, {31'b0, wb_valid}, 32'd0);

    // Table of single accesses.
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Write-back backpressure: result held, no second accept until drained.
    wb_ready      = 1'b0;
    mem_out_valid = 1'b1;
    wdata_gpr_i   = 32'hAAAA_0001;
    @(negedge clk);
    wdata_gpr_i = 32'hBBBB_0002;
    for (int k = 0; k < 3; k++) begin
      chk("bp_wb_valid", k, {31'b0, wb_valid}, 32'd1);
      chk("bp_wb_hold", k, wdata_gpr_o, 32'hAAAA_0001);
      chk("bp_wb_ready", k, {31'b0, mem_out_ready}, 32'd0);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_wb_release", 0, {31'b0, mem_out_ready}, 32'd1);
    @(negedge clk);
    mem_out_valid = 1'b0;
    chk("bp_wb_next", 0, wdata_gpr_o, 32'hBBBB_0002);
    chk("bp_wb_next_valid", 0, {31'b0, wb_valid}, 32'd1);
    @(negedge clk);
    chk("bp_wb_empty", 0, {31'b0, wb_valid}, 32'd0);

    // Bus request backpressure: dreq_ready low for three cycles.
    mem_out_valid   = 1'b1;
    sram_read_write = 2'b01;
    Mem_Mask        = 3'b010;
    alu_result      = 32'h8000_0020;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      chk("bp_req_valid", k, {31'b0, dbus.dreq_valid}, 32'd1);
      chk("bp_req_addr", k, dbus.dreq_addr, 32'h8000_0020);
      chk("bp_req_ready", k, {31'b0, mem_out_ready}, 32'd0);
      @(negedge clk);
    end
    dbus.dreq_ready = 1'b1;
    @(negedge clk);
    dbus.dreq_ready = 1'b0;
    chk("bp_req_wait", 0, {31'b0, mem_out_ready}, 32'd0);
    dbus.drsp_valid = 1'b1;
    dbus.drsp_rdata = 32'h0000_1234;
    @(negedge clk);
    dbus.drsp_valid = 1'b0;
    chk("bp_req_wb", 0, {31'b0, wb_valid}, 32'd1);
    chk("bp_req_data", 0, wdata_gpr_o, 32'h0000_1234);
    @(negedge clk);

    // Reset during WAIT, then a stale response arrives.
    mem_out_valid   = 1'b1;
    sram_read_write = 2'b01;
    Mem_Mask        = 3'b010;
    alu_result      = 32'h8000_0040;
    wdata_gpr_i     = 32'h7777_7777;
    dbus.dreq_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    dbus.dreq_ready = 1'b1;
    @(negedge clk);
    dbus.dreq_ready = 1'b0;
    chk("rw_in_wait", 0, {31'b0, mem_is_load}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rw_rst_is_load", 0, {31'b0, mem_is_load}, 32'd0);
    chk("rw_rst_gpr", 0, wdata_gpr_o, 32'd0);
    @(negedge clk);
    reset           = 1'b1;
    dbus.drsp_valid = 1'b1;
    dbus.drsp_rdata = 32'hAAAA_5555;
    @(negedge clk);
    dbus.drsp_valid = 1'b0;
    chk("rw_no_wb", 0, {31'b0, wb_valid}, 32'd0);
    chk("rw_idle", 0, {31'b0, mem_out_ready}, 32'd1);
    chk("rw_is_load", 0, {31'b0, mem_is_load}, 32'd0);
    chk("rw_gpr", 0, wdata_gpr_o, 32'd0);
    @(negedge clk);
    chk("rw_still_no_wb", 0, {31'b0, wb_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
